// File: rtl/flaw_pkg.sv
// ============================================================================
// Module   : flaw_pkg
// Brief    : Shared sync byte, header layout and FSM encoding for the burst reader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package flaw_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Header word: sync byte in the top byte, then sequence number, then word count.
  typedef struct packed {
    logic [7:0]  sync;
    logic [7:0]  seq;
    logic [15:0] words;
  } hdr_t;

  function automatic hdr_t make_header(input logic [7:0] sync,
                                       input logic [7:0] seq,
                                       input logic [15:0] words);
    hdr_t h;
    h.sync  = sync;
    h.seq   = seq;
    h.words = words;
    return h;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skid_buf2.sv
// ============================================================================
// Module   : skid_buf2
// Brief    : Two-entry skid buffer with bypass of the word arriving this cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module skid_buf2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic         o_head_valid,
  output logic [W-1:0] o_head_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   count_q;
  logic         bypass;
  logic         wr;
  logic         rd;

  // An arriving word popped while the buffer is empty goes straight through.
  assign bypass = i_pop && (count_q == 2'd0);
  assign wr     = i_push && !bypass;
  assign rd     = i_pop && (count_q != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr) begin
        mem_q[wptr_q] <= i_push_data;
      end
      wptr_q  <= wptr_q ^ wr;
      rptr_q  <= rptr_q ^ rd;
      count_q <= count_q + {1'b0, wr} - {1'b0, rd};
    end
  end

  assign o_head_valid = (count_q != 2'd0) || i_push;
  assign o_head_data  = (count_q != 2'd0) ? mem_q[rptr_q] : i_push_data;
  assign o_count      = count_q;

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module   : fifo_burst_reader
// Brief    : Reads a frame of words from a FIFO and emits header + data on a
//            valid/ready stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_burst_reader
  import flaw_pkg::*;
#(
  parameter int unsigned FRAME_W = 16,
  parameter logic [7:0]  SYNC    = SYNC_BYTE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [FRAME_W-1:0] i_frame_words,
  output logic               o_fifo_rreq,
  input  logic               i_fifo_empty,
  input  logic [31:0]        i_fifo_rdata,
  output logic [31:0]        o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_sop,
  output logic               o_eop,
  output logic               o_busy,
  output logic               o_done
);

  state_e             state_q, state_d;
  logic [7:0]         seq_q, seq_d;
  logic [FRAME_W-1:0] words_q, words_d;
  logic [FRAME_W-1:0] remain_q, remain_d;
  logic [FRAME_W-1:0] reqcnt_q, reqcnt_d;
  logic               inflight_q;

  logic               skid_pop;
  logic               skid_valid;
  logic [31:0]        skid_data;
  logic [1:0]         skid_count;
  logic [2:0]         occ;
  logic               rreq;

  skid_buf2 #(.W(32)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .i_push       (inflight_q),
    .i_push_data  (i_fifo_rdata),
    .i_pop        (skid_pop),
    .o_head_valid (skid_valid),
    .o_head_data  (skid_data),
    .o_count      (skid_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      seq_q      <= 8'd0;
      words_q    <= '0;
      remain_q   <= '0;
      reqcnt_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      words_q    <= words_d;
      remain_q   <= remain_d;
      reqcnt_q   <= reqcnt_d;
      inflight_q <= rreq;
    end
  end

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    words_d  = words_q;
    remain_d = remain_q;
    reqcnt_d = reqcnt_q;
    o_valid  = 1'b0;
    o_sop    = 1'b0;
    o_eop    = 1'b0;
    o_data   = '0;
    skid_pop = 1'b0;
    o_busy   = (state_q != ST_IDLE);
    o_done   = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_HDR;
          words_d  = i_frame_words;
          remain_d = i_frame_words;
          reqcnt_d = '0;
        end
      end
      ST_HDR: begin
        o_valid = 1'b1;
        o_sop   = 1'b1;
        o_eop   = (words_q == '0);
        o_data  = make_header(SYNC, seq_q, 16'(words_q));
        if (i_ready) begin
          state_d = (words_q == '0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        o_valid  = skid_valid;
        o_data   = skid_valid ? skid_data : 32'd0;
        o_eop    = skid_valid && (remain_q == FRAME_W'(1));
        skid_pop = skid_valid && i_ready;
        if (skid_pop) begin
          remain_d = remain_q - FRAME_W'(1);
          if (remain_q == FRAME_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        seq_d   = seq_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Occupancy counts the word leaving this cycle as gone, so a full-rate
    // stream keeps one read in flight every cycle.
    occ  = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, skid_pop};
    rreq = ((state_q == ST_HDR) || (state_q == ST_DATA)) && !i_fifo_empty &&
           (occ < 3'd2) && (reqcnt_q < words_q);
    if (rreq) begin
      reqcnt_d = reqcnt_q + FRAME_W'(1);
    end
  end

  assign o_fifo_rreq = rreq;

endmodule

`default_nettype wire
